pid_sample_scheduler: RTL



---
 rtl/pid_sample_scheduler_pkg.sv | 21 ++
 rtl/pid_sample_scheduler_if.sv | 47 ++++
 rtl/pid_sample_scheduler_period_timer.sv | 36 +++
 rtl/pid_sample_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pid_sample_scheduler_pkg.sv
// Shared encodings and defaults for the PID sample scheduler and its period timer.
package pid_sched_pkg;

  localparam int ADC_BITWIDTH_DEF    = 8;
  localparam int PERIOD_BITWIDTH_DEF = 16;
  localparam int TIMEOUT_CYCLES_DEF  = 1023;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADC_REQ   = 3'd1,
    ST_ADC_WAIT  = 3'd2,
    ST_PID_START = 3'd3,
    ST_PID_RUN   = 3'd4,
    ST_UPDATE    = 3'd5
  } sched_state_e;

  localparam sched_state_e STATE_RESET = ST_IDLE;
  localparam logic         FLAG_RESET  = 1'b0;
  localparam logic         STROBE_RESET = 1'b0;

endpackage

// File: rtl/pid_sample_scheduler_if.sv
// Handshake bundle between the scheduler and the ADC interface, PID core and PWM stage.
interface pid_sample_scheduler_if
  import pid_sched_pkg::*;
#(
  parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF
);

  logic                           adc_start_o;
  logic                           adc_done_i;
  logic        [ADC_BITWIDTH-1:0] adc_data_i;
  logic        [ADC_BITWIDTH-1:0] ADC_value_o;
  logic        [ADC_BITWIDTH-1:0] SET_value_o;
  logic                           pid_start_o;
  logic                           pid_done_i;
  logic signed [ADC_BITWIDTH:0]   pid_out_i;
  logic signed [ADC_BITWIDTH:0]   out_value_o;
  logic                           update_o;

  // Scheduler side.
  modport master (
    output adc_start_o,
    input  adc_done_i,
    input  adc_data_i,
    output ADC_value_o,
    output SET_value_o,
    output pid_start_o,
    input  pid_done_i,
    input  pid_out_i,
    output out_value_o,
    output update_o
  );

  // ADC / PID core / PWM side.
  modport slave (
    input  adc_start_o,
    output adc_done_i,
    output adc_data_i,
    input  ADC_value_o,
    input  SET_value_o,
    input  pid_start_o,
    output pid_done_i,
    output pid_out_i,
    input  out_value_o,
    input  update_o
  );

endinterface

// File: rtl/pid_sample_scheduler_period_timer.sv
// Free-running sample-period counter; pulses tick_o on the last count of each period.
module period_timer
  import pid_sched_pkg::*;
#(
  parameter int PERIOD_BITWIDTH = PERIOD_BITWIDTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       enable_i,
  input  logic [PERIOD_BITWIDTH-1:0] period_i,
  output logic                       tick_o
);

  logic [PERIOD_BITWIDTH-1:0] count_q;
  logic [PERIOD_BITWIDTH-1:0] count_d;
  logic                       running;

  // period_i is compared live: shrinking it below the count lets the counter wrap through 2^N.
  always_comb begin
    running = enable_i && (period_i != '0);
    tick_o  = running && (count_q == (period_i - PERIOD_BITWIDTH'(1)));
    count_d = count_q + PERIOD_BITWIDTH'(1);
    if (!running || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pid_sample_scheduler.sv
// Sequences one PID control iteration per sample tick: ADC request, operand latch,
// PID start, result capture and PWM update strobe, with watchdog and overrun flags.
module pid_sample_scheduler
  import pid_sched_pkg::*;
#(
  parameter int ADC_BITWIDTH    = ADC_BITWIDTH_DEF,
  parameter int PERIOD_BITWIDTH = PERIOD_BITWIDTH_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       enable_i,
  input  logic [PERIOD_BITWIDTH-1:0] period_i,
  input  logic                       clr_flags_i,
  input  logic [ADC_BITWIDTH-1:0]    set_value_i,
  pid_sample_scheduler_if.master     bus,
  output logic                       busy_o,
  output logic                       overrun_o,
  output logic                       timeout_o
);

  localparam int WD_BITWIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_BITWIDTH-1:0] WD_LAST = WD_BITWIDTH'(TIMEOUT_CYCLES - 1);

  sched_state_e                state_q, state_d;
  logic [WD_BITWIDTH-1:0]      wd_q, wd_d;
  logic                        adc_start_q, adc_start_d;
  logic                        pid_start_q, pid_start_d;
  logic                        update_q, update_d;
  logic [ADC_BITWIDTH-1:0]     adc_value_q, adc_value_d;
  logic [ADC_BITWIDTH-1:0]     set_value_q, set_value_d;
  logic signed [ADC_BITWIDTH:0] out_value_q, out_value_d;
  logic                        overrun_q, overrun_d;
  logic                        timeout_q, timeout_d;
  logic                        tick;
  logic                        wd_expired;
  logic                        overrun_set;
  logic                        timeout_set;

  period_timer #(
    .PERIOD_BITWIDTH (PERIOD_BITWIDTH)
  ) u_period_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .enable_i (enable_i),
    .period_i (period_i),
    .tick_o   (tick)
  );

  // The watchdog reaches TIMEOUT_CYCLES on the same edge the flag is raised; a done strobe
  // in that last waiting cycle is tested first and therefore wins.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    adc_start_d = 1'b0;
    pid_start_d = 1'b0;
    update_d    = 1'b0;
    adc_value_d = adc_value_q;
    set_value_d = set_value_q;
    out_value_d = out_value_q;
    timeout_set = 1'b0;
    wd_expired  = (wd_q == WD_LAST);
    overrun_set = tick && (state_q != ST_IDLE);

    if (!enable_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_d     = ST_ADC_REQ;
            adc_start_d = 1'b1;
          end
        end
        ST_ADC_REQ: begin
          state_d = ST_ADC_WAIT;
          wd_d    = '0;
        end
        ST_ADC_WAIT: begin
          if (bus.adc_done_i) begin
            adc_value_d = bus.adc_data_i;
            set_value_d = set_value_i;
            pid_start_d = 1'b1;
            state_d     = ST_PID_START;
          end else if (wd_expired) begin
            timeout_set = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            wd_d = wd_q + WD_BITWIDTH'(1);
          end
        end
        ST_PID_START: begin
          state_d = ST_PID_RUN;
          wd_d    = '0;
        end
        ST_PID_RUN: begin
          if (bus.pid_done_i) begin
            out_value_d = bus.pid_out_i;
            update_d    = 1'b1;
            state_d     = ST_UPDATE;
          end else if (wd_expired) begin
            timeout_set = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            wd_d = wd_q + WD_BITWIDTH'(1);
          end
        end
        ST_UPDATE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    overrun_d = overrun_q;
    if (clr_flags_i) begin
      overrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end

    timeout_d = timeout_q;
    if (clr_flags_i) begin
      timeout_d = 1'b0;
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= STATE_RESET;
      wd_q        <= '0;
      adc_start_q <= STROBE_RESET;
      pid_start_q <= STROBE_RESET;
      update_q    <= STROBE_RESET;
      adc_value_q <= '0;
      set_value_q <= '0;
      out_value_q <= '0;
      overrun_q   <= FLAG_RESET;
      timeout_q   <= FLAG_RESET;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      adc_start_q <= adc_start_d;
      pid_start_q <= pid_start_d;
      update_q    <= update_d;
      adc_value_q <= adc_value_d;
      set_value_q <= set_value_d;
      out_value_q <= out_value_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.adc_start_o = adc_start_q;
  assign bus.pid_start_o = pid_start_q;
  assign bus.update_o    = update_q;
  assign bus.ADC_value_o = adc_value_q;
  assign bus.SET_value_o = set_value_q;
  assign bus.out_value_o = out_value_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign overrun_o       = overrun_q;
  assign timeout_o       = timeout_q;

endmodule
